// File: rtl/ram_pkg.sv
// Shared definitions for the two-requester RAM arbiter.
//   DefDataWidth / DefAddrWidth : default RAM word and address widths
//   REQ0 / REQ1                 : requester indices
//   RD / WR                     : request opcode values carried on reqN_we
package ram_pkg;

  localparam int unsigned DefDataWidth = 4;
  localparam int unsigned DefAddrWidth = 8;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;

endpackage

// File: rtl/ram_rr_arbiter_if.sv
// Bundles both requester handshakes, both response channels and the RAM-side bus.
//   slave  : arbiter view (takes requests and ram_r_data, drives ready/rsp/RAM controls)
//   master : client/RAM view (drives requests and ram_r_data, observes the rest)
interface ram_rr_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned ADDR_WIDTH = 8
);

  logic                  req0_valid, req1_valid;
  logic                  req0_we,    req1_we;
  logic [ADDR_WIDTH-1:0] req0_addr,  req1_addr;
  logic [DATA_WIDTH-1:0] req0_wdata, req1_wdata;
  logic                  req0_ready, req1_ready;
  logic                  rsp0_valid, rsp1_valid;
  logic [DATA_WIDTH-1:0] rsp0_rdata, rsp1_rdata;
  logic                  ram_wr_en;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_w_data;
  logic [DATA_WIDTH-1:0] ram_r_data;

  modport slave (
    input  req0_valid, req1_valid, req0_we, req1_we, req0_addr, req1_addr,
    input  req0_wdata, req1_wdata, ram_r_data,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata,
    output ram_wr_en, ram_addr, ram_w_data
  );

  modport master (
    output req0_valid, req1_valid, req0_we, req1_we, req0_addr, req1_addr,
    output req0_wdata, req1_wdata, ram_r_data,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata,
    input  ram_wr_en, ram_addr, ram_w_data
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant with a last_grant register.
//   clk, reset : clock and synchronous active-high reset
//   valid[1:0] : request lines, bit n = requester n
//   advance    : a transfer happened this cycle; last_grant follows the grant
//   grant[1:0] : one-hot (or zero) combinational grant, forced low during reset
module rr_arbiter2
  import ram_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_q, last_d;

  always_comb begin
    grant = 2'b00;
    if (!reset) begin
      if (valid == 2'b11) begin
        // Tie goes to whoever was not granted last.
        grant = (last_q == REQ1) ? 2'b01 : 2'b10;
      end else begin
        grant = valid;
      end
    end
    last_d = advance ? grant[REQ1] : last_q;
  end

  // Reset to REQ1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) last_q <= REQ1;
    else       last_q <= last_d;
  end

endmodule

// File: rtl/ram_rr_arbiter.sv
// Shares one single-port RAM (sync write, registered read address) between two requesters.
//   clk, reset : clock and synchronous active-high reset
//   bus        : requester handshakes, per-requester read responses and the RAM bus
// Read data returns on rspN one cycle after the grant; writes produce no response.
module ram_rr_arbiter
  import ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth
) (
  input  logic            clk,
  input  logic            reset,
  ram_rr_arbiter_if.slave bus
);

  logic [1:0]            grant;
  logic                  transfer;
  logic                  gnt_idx;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  rsp_pend_q, rsp_pend_d;
  logic                  rsp_id_q, rsp_id_d;
  logic                  rsp0_hit, rsp1_hit;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .valid   ({bus.req1_valid, bus.req0_valid}),
    .advance (transfer),
    .grant   (grant)
  );

  always_comb begin
    transfer = |grant;
    gnt_idx  = grant[REQ1];

    if (gnt_idx == REQ1) begin
      sel_we    = bus.req1_we;
      sel_addr  = bus.req1_addr;
      sel_wdata = bus.req1_wdata;
    end else begin
      sel_we    = bus.req0_we;
      sel_addr  = bus.req0_addr;
      sel_wdata = bus.req0_wdata;
    end

    bus.req0_ready = grant[REQ0];
    bus.req1_ready = grant[REQ1];

    // Idle cycles park the RAM on the last granted address with zero write data.
    bus.ram_wr_en  = transfer & (sel_we == WR);
    bus.ram_addr   = transfer ? sel_addr : addr_q;
    bus.ram_w_data = transfer ? sel_wdata : '0;

    addr_d     = transfer ? sel_addr : addr_q;
    rsp_pend_d = transfer & (sel_we == RD);
    rsp_id_d   = gnt_idx;

    // Gate with reset so a read granted just before reset never responds.
    rsp0_hit = rsp_pend_q & (rsp_id_q == REQ0) & ~reset;
    rsp1_hit = rsp_pend_q & (rsp_id_q == REQ1) & ~reset;

    bus.rsp0_valid = rsp0_hit;
    bus.rsp1_valid = rsp1_hit;
    bus.rsp0_rdata = rsp0_hit ? bus.ram_r_data : '0;
    bus.rsp1_rdata = rsp1_hit ? bus.ram_r_data : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q     <= '0;
      rsp_pend_q <= 1'b0;
      rsp_id_q   <= REQ0;
    end else begin
      addr_q     <= addr_d;
      rsp_pend_q <= rsp_pend_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Self-checking bench for ram_rr_arbiter: a table of per-cycle requests with expected
// grants, a reference memory, and a response scoreboard queue.
module tb_ram_rr_arbiter;
  import ram_pkg::*;

  localparam int unsigned DW = DefDataWidth;
  localparam int unsigned AW = DefAddrWidth;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ram_rr_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ram_rr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural single-port RAM: sync write, registered read address.
  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] raddr_q;
  always @(posedge clk) begin
    if (bus.ram_wr_en) mem[bus.ram_addr] <= bus.ram_w_data;
    raddr_q <= bus.ram_addr;
  end
  assign bus.ram_r_data = mem[raddr_q];

  typedef struct {
    logic          rst;
    logic          v0, we0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          v1, we1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          r0, r1;
  } vec_t;

  typedef struct {
    int            due;
    logic          id;
    logic [DW-1:0] data;
  } rsp_t;

  vec_t          vecs[$];
  rsp_t          rsp_q[$];
  logic [DW-1:0] ref_mem [2**AW];
  logic [AW-1:0] last_addr;
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;

  function automatic vec_t mk(logic rst, logic v0, logic we0, logic [AW-1:0] a0,
                              logic [DW-1:0] d0, logic v1, logic we1, logic [AW-1:0] a1,
                              logic [DW-1:0] d1, logic r0, logic r1);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.we0 = we0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.we1 = we1; v.a1 = a1; v.d1 = d1; v.r0 = r0; v.r1 = r1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input vec_t v);
    rsp_t          r;
    logic          e_v0, e_v1, e_we;
    logic [DW-1:0] e_rd0, e_rd1, e_wd;
    logic [AW-1:0] e_addr;
    e_v0 = 1'b0; e_v1 = 1'b0; e_rd0 = '0; e_rd1 = '0;

    @(negedge clk);
    cyc++;
    reset          = v.rst;
    bus.req0_valid = v.v0; bus.req0_we = v.we0; bus.req0_addr = v.a0; bus.req0_wdata = v.d0;
    bus.req1_valid = v.v1; bus.req1_we = v.we1; bus.req1_addr = v.a1; bus.req1_wdata = v.d1;
    #1;

    chk("req0_ready", 32'(bus.req0_ready), 32'(v.r0));
    chk("req1_ready", 32'(bus.req1_ready), 32'(v.r1));

    if (v.rst) begin
      rsp_q.delete();
    end else if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
      r = rsp_q.pop_front();
      if (r.id == REQ1) begin e_v1 = 1'b1; e_rd1 = r.data; end
      else              begin e_v0 = 1'b1; e_rd0 = r.data; end
    end
    chk("rsp0_valid", 32'(bus.rsp0_valid), 32'(e_v0));
    chk("rsp0_rdata", 32'(bus.rsp0_rdata), 32'(e_rd0));
    chk("rsp1_valid", 32'(bus.rsp1_valid), 32'(e_v1));
    chk("rsp1_rdata", 32'(bus.rsp1_rdata), 32'(e_rd1));

    e_we = (v.r0 & v.we0) | (v.r1 & v.we1);
    chk("ram_wr_en", 32'(bus.ram_wr_en), 32'(e_we));

    if (v.rst) begin
      last_addr = '0;
    end else begin
      if (v.r0)      begin e_addr = v.a0;      e_wd = v.d0; end
      else if (v.r1) begin e_addr = v.a1;      e_wd = v.d1; end
      else           begin e_addr = last_addr; e_wd = '0;   end
      chk("ram_addr", 32'(bus.ram_addr), 32'(e_addr));
      chk("ram_w_data", 32'(bus.ram_w_data), 32'(e_wd));
      last_addr = e_addr;
      if (v.r0 | v.r1) begin
        if (e_we) ref_mem[e_addr] = e_wd;
        else      rsp_q.push_back('{due: cyc + 1, id: v.r1, data: ref_mem[e_addr]});
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_we = 1'b0; bus.req0_addr = '0; bus.req0_wdata = '0;
    bus.req1_valid = 1'b0; bus.req1_we = 1'b0; bus.req1_addr = '0; bus.req1_wdata = '0;
    last_addr = '0;

    //                rst v0 we0 a0     d0    v1 we1 a1     d1    r0 r1
    vecs.push_back(mk(1, 0, 0, 8'h00, 4'h0, 0, 0, 8'h00, 4'h0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'h00, 4'h0, 0, 0, 8'h00, 4'h0, 0, 0));
    // Write then read back on requester 0.
    vecs.push_back(mk(0, 1, 1, 8'h10, 4'hA, 0, 0, 8'h00, 4'h0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 8'h10, 4'h0, 0, 0, 8'h00, 4'h0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 4'h0, 0, 0, 8'h00, 4'h0, 0, 0));
    // Preload, then contended reads alternate 0,1,0,1.
    vecs.push_back(mk(0, 1, 1, 8'h01, 4'h3, 0, 0, 8'h00, 4'h0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 4'h0, 1, 1, 8'h02, 4'h5, 0, 1));
    vecs.push_back(mk(0, 1, 0, 8'h01, 4'h0, 1, 0, 8'h02, 4'h0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 8'h01, 4'h0, 1, 0, 8'h02, 4'h0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 8'h01, 4'h0, 1, 0, 8'h02, 4'h0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 8'h01, 4'h0, 1, 0, 8'h02, 4'h0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 8'h00, 4'h0, 0, 0, 8'h00, 4'h0, 0, 0));
    // Requester 1 alone for 4 cycles, then requester 0 joins and wins the tie.
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 0, 0, 8'h00, 4'h0, 1, 0, 8'h02, 4'h0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 8'h01, 4'h0, 1, 0, 8'h02, 4'h0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 8'h01, 4'h0, 1, 0, 8'h02, 4'h0, 0, 1));
    // Cross-requester read-after-write.
    vecs.push_back(mk(0, 0, 0, 8'h00, 4'h0, 1, 1, 8'h20, 4'h7, 0, 1));
    vecs.push_back(mk(0, 1, 0, 8'h20, 4'h0, 0, 0, 8'h00, 4'h0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 4'h0, 0, 0, 8'h00, 4'h0, 0, 0));

    foreach (vecs[i]) step(vecs[i]);

    // Read granted right before reset: its response must be dropped.
    step(mk(0, 1, 0, 8'h10, 4'h0, 0, 0, 8'h00, 4'h0, 1, 0));
    step(mk(1, 1, 1, 8'h33, 4'hF, 1, 1, 8'h44, 4'hE, 0, 0));
    step(mk(1, 1, 1, 8'h33, 4'hF, 1, 1, 8'h44, 4'hE, 0, 0));
    // After reset a tie goes to requester 0.
    step(mk(0, 1, 0, 8'h01, 4'h0, 1, 0, 8'h02, 4'h0, 1, 0));
    step(mk(0, 0, 0, 8'h00, 4'h0, 0, 0, 8'h00, 4'h0, 0, 0));

    // Address extremes.
    step(mk(0, 1, 1, 8'hFF, 4'hC, 0, 0, 8'h00, 4'h0, 1, 0));
    step(mk(0, 0, 0, 8'h00, 4'h0, 1, 1, 8'h00, 4'h9, 0, 1));
    step(mk(0, 1, 0, 8'hFF, 4'h0, 0, 0, 8'h00, 4'h0, 1, 0));
    step(mk(0, 0, 0, 8'h00, 4'h0, 1, 0, 8'h00, 4'h0, 0, 1));
    step(mk(0, 0, 0, 8'h00, 4'h0, 0, 0, 8'h00, 4'h0, 0, 0));
    step(mk(0, 0, 0, 8'h00, 4'h0, 0, 0, 8'h00, 4'h0, 0, 0));

    chk("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
